mux_arbiter_2x8: RTL and testbench

- Round-robin arbiter and sequencer for a shared 8-bit 2:1 datapath mux.
- Two requesters (e.g. turkey-count source and display/test source) contend for one 8-bit output path. The block grants ownership, drives the mux select and registers the selected byte with a valid flag.
- A hold counter bounds how long one owner can keep the path while the other requester waits.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/arb2_next_owner.sv | 28 ++
 rtl/mux_arbiter_2x8.sv | 76 +++++++
 tb/tb_mux_arbiter_2x8.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding and sizing constants for the 2x8 mux arbiter
package mux_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;
    localparam int DATA_W       = 8;
    localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/arb2_next_owner.sv
// arb2_next_owner: next-owner decision for the 2-requester arbiter (ARB_FIXED_PRIO_EN selects fixed priority)
module arb2_next_owner
    import mux_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic       hold_sat,
    output arb_state_t nxt
);
    logic pre0;
`ifdef ARB_FIXED_PRIO_EN
    assign pre0 = 1'b0;
`else
    assign pre0 = 1'b1;
`endif
    // Ties go to the requester that did not own last; a saturated hold yields to a waiting peer
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = (req0 && req1) ? (last ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
            OWN0:    nxt = !req0 ? (req1 ? OWN1 : IDLE) : (req1 && hold_sat && pre0) ? OWN1 : OWN0;
            OWN1:    nxt = !req1 ? (req0 ? OWN0 : IDLE) : (req0 && hold_sat) ? OWN0 : OWN1;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/mux_arbiter_2x8.sv
// mux_arbiter_2x8: round-robin owner of a shared 8-bit 2:1 mux with registered output (ARB_FIXED_PRIO_EN gives req0 fixed priority)
module mux_arbiter_2x8
    import mux_arb_pkg::*;
#(
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int CNT_W    = $clog2(MAX_HOLD) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] o,
    output logic              o_valid
);
    arb_state_t       state;
    arb_state_t       nxt;
    logic             last;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_sat;
    logic             own_valid;

    assign hold_sat  = hold_cnt == CNT_W'(MAX_HOLD - 1);
    assign gnt0      = state == OWN0;
    assign gnt1      = state == OWN1;
    assign sel       = gnt1;
    assign own_valid = (gnt0 && req0) || (gnt1 && req1);

    arb2_next_owner u_next (
        .state    (state),
        .req0     (req0),
        .req1     (req1),
        .last     (last),
        .hold_sat (hold_sat),
        .nxt      (nxt)
    );

    // Owner register and hold counter: cleared on every new grant, saturating while the owner stays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= nxt;
            hold_cnt <= (nxt != state) ? '0 : (state != IDLE && !hold_sat) ? hold_cnt + CNT_W'(1) : hold_cnt;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign last = 1'b1;
`else
    // Remember the latest owner so simultaneous requests alternate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (nxt != state && nxt != IDLE)
            last <= nxt == OWN1;
    end
`endif

    // Register the selected byte only while the owner is requesting; o holds its last value otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o       <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= own_valid;
            if (own_valid)
                o <= sel ? in1 : in0;
        end
    end
endmodule

// File: tb/tb_mux_arbiter_2x8.sv
// tb_mux_arbiter_2x8: directed stimulus with a per-cycle owner model plus literal spot checks
module tb_mux_arbiter_2x8;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] in0, in1;
    logic       gnt0, gnt1, sel, o_valid;
    logic [7:0] o;

    int checks = 0;
    int errors = 0;

    int         m_owner, m_last, m_ten, m_nx;
    logic [7:0] m_o;
    logic       m_valid;
    logic       m_own_req;

    mux_arbiter_2x8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .in0     (in0),
        .in1     (in1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .o       (o),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // owner: -1 none, 0 or 1; ten = cycles held since the grant
    function automatic int next_owner(int own, int lst, int ten, logic r0, logic r1);
        logic mine, other;
        if (own < 0)
            return (r0 && r1) ? 1 - lst : r0 ? 0 : r1 ? 1 : -1;
        mine  = (own == 0) ? r0 : r1;
        other = (own == 0) ? r1 : r0;
        if (!mine)
            return other ? 1 - own : -1;
        if (other && ten >= MAX_HOLD - 1)
            return 1 - own;
        return own;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= 1;
            m_ten   <= 0;
            m_o     <= 8'h00;
            m_valid <= 1'b0;
        end else begin
            m_nx      = next_owner(m_owner, m_last, m_ten, req0, req1);
            m_own_req = (m_owner == 0 && req0) || (m_owner == 1 && req1);
            m_valid  <= m_own_req;
            if (m_own_req)
                m_o <= (m_owner == 1) ? in1 : in0;
            m_ten   <= (m_nx == m_owner) ? m_ten + 1 : 0;
            m_last  <= (m_nx >= 0 && m_nx != m_owner) ? m_nx : m_last;
            m_owner <= m_nx;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_gnt0", 8'(gnt0), 8'(m_owner == 0));
        chk("model_gnt1", 8'(gnt1), 8'(m_owner == 1));
        chk("model_sel", 8'(sel), 8'(m_owner == 1));
        chk("model_o_valid", 8'(o_valid), 8'(m_valid));
        chk("model_o", o, m_o);
        chk("mutex", 8'(gnt0 & gnt1), 8'h00);
    end

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        in0 = 8'h00;
        in1 = 8'h00;
        repeat (3) tick();
        chk("rst_gnt0", 8'(gnt0), 8'h00);
        chk("rst_gnt1", 8'(gnt1), 8'h00);
        chk("rst_sel", 8'(sel), 8'h00);
        chk("rst_o", o, 8'h00);
        chk("rst_o_valid", 8'(o_valid), 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_gnt", 8'({gnt0, gnt1}), 8'h00);
        chk("idle_o_valid", 8'(o_valid), 8'h00);

        req0 = 1'b1;
        in0 = 8'hA5;
        tick();
        chk("single_gnt0_c1", 8'(gnt0), 8'h01);
        chk("single_valid_c1", 8'(o_valid), 8'h00);
        tick();
        chk("single_o_c2", o, 8'hA5);
        chk("single_valid_c2", 8'(o_valid), 8'h01);
        repeat (4) tick();
        req0 = 1'b0;
        tick();
        chk("single_gnt0_c7", 8'(gnt0), 8'h00);
        chk("single_valid_c7", 8'(o_valid), 8'h00);
        chk("single_o_hold", o, 8'hA5);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req0 = 1'b1;
        req1 = 1'b1;
        in0 = 8'h11;
        in1 = 8'h22;
        tick();
        chk("tie_first_gnt0", 8'(gnt0), 8'h01);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            chk("tie_hold_gnt0", 8'(gnt0), 8'h01);
        end
        tick();
        chk("preempt_gnt1", 8'(gnt1), 8'h01);
        chk("preempt_sel", 8'(sel), 8'h01);
        chk("preempt_gnt0", 8'(gnt0), 8'h00);
        tick();
        chk("preempt_o", o, 8'h22);
        chk("preempt_valid", 8'(o_valid), 8'h01);
        repeat (MAX_HOLD - 2) tick();
        chk("back_hold_gnt1", 8'(gnt1), 8'h01);
        tick();
        chk("back_gnt0", 8'(gnt0), 8'h01);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("both_drop_idle", 8'({gnt0, gnt1}), 8'h00);

        req0 = 1'b1;
        in0 = 8'h5A;
        tick();
        chk("ho_gnt0", 8'(gnt0), 8'h01);
        req1 = 1'b1;
        in1 = 8'h3C;
        repeat (2) tick();
        req0 = 1'b0;
        tick();
        chk("ho_gnt1", 8'(gnt1), 8'h01);
        chk("ho_sel", 8'(sel), 8'h01);
        chk("ho_gnt0", 8'(gnt0), 8'h00);
        tick();
        chk("ho_o", o, 8'h3C);
        chk("ho_valid", 8'(o_valid), 8'h01);
        req1 = 1'b0;
        tick();
        chk("ho_idle", 8'({gnt0, gnt1}), 8'h00);

        req0 = 1'b1;
        in0 = 8'h77;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("uncontested_gnt0", 8'(gnt0), 8'h01);
        end
        req1 = 1'b1;
        tick();
        chk("sat_preempt_gnt1", 8'(gnt1), 8'h01);
        tick();
        chk("own1_valid", 8'(o_valid), 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt1", 8'(gnt1), 8'h00);
        chk("async_sel", 8'(sel), 8'h00);
        chk("async_valid", 8'(o_valid), 8'h00);
        chk("async_o", o, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rearb_gnt0", 8'(gnt0), 8'h01);
        chk("rearb_gnt1", 8'(gnt1), 8'h00);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
